// File: rtl/spi_slave_frontend.sv
// Oversampled SPI slave (mode 0). The SPI pins are sampled on clk.
// Received 32-bit frames are handed to the main FSM through rdy_spi/ack_fetch_spi.
// The pushed tx word is shifted back out on miso during the next frame.
module spi_slave_frontend #(
  parameter int LEN_SPI     = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sclk,
  input  logic               cs_n,
  input  logic               mosi,
  output logic               miso,
  output logic [LEN_SPI-1:0] rx_output,
  output logic               rdy_spi,
  output logic               spi_busy,
  input  logic               ack_fetch_spi,
  input  logic [LEN_SPI-1:0] tx_input,
  input  logic               push_tx,
  output logic               overrun,
  output logic               frame_err
);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] flush_q, flush_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, primed;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [LEN_SPI-1:0]     rx_shift_q, rx_shift_d;
  logic [LEN_SPI-1:0]     tx_shift_q, tx_shift_d;
  logic [LEN_SPI-1:0]     tx_buf_q, tx_buf_d;
  logic [LEN_SPI-1:0]     rx_out_q, rx_out_d;
  logic                   rdy_q, rdy_d, busy_q, busy_d, ovr_q, ovr_d, ferr_q, ferr_d;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  // The cs_n chain resets to 1. It is only trusted after every stage holds a real sample.
  assign primed    = flush_q[SYNC_STAGES-1];

  // Next values for the pin synchronisers and the flush tracker.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    flush_d     = {flush_q[SYNC_STAGES-2:0], 1'b1};
    sclk_prev_d = sclk_s;
  end

  // Synchroniser registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      flush_q     <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      flush_q     <= flush_d;
      sclk_prev_q <= sclk_prev_d;
    end
  end

  // Next state, shift registers, tx buffer and handshake flags.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    tx_buf_d   = tx_buf_q;
    rx_out_d   = rx_out_q;
    rdy_d      = rdy_q;
    busy_d     = busy_q;
    ovr_d      = ovr_q;
    ferr_d     = 1'b0;

    if (push_tx && state_q != SHIFT) tx_buf_d = tx_input;
    // The ack is applied first, so a DONE in the same cycle sees the slot as free.
    if (ack_fetch_spi && rdy_q) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end

    case (state_q)
      WAIT_IDLE: if (primed && cs_s) state_d = IDLE;
      IDLE: if (!cs_s) begin
        state_d    = SHIFT;
        bit_cnt_d  = '0;
        tx_shift_d = tx_buf_q;
        busy_d     = 1'b1;
      end
      SHIFT: begin
        if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[LEN_SPI-2:0], mosi_s};
          if (bit_cnt_q != CNT_W'(LEN_SPI + 1)) bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (sclk_fall) tx_shift_d = {tx_shift_q[LEN_SPI-2:0], 1'b0};
        if (cs_s) state_d = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (bit_cnt_q == CNT_W'(LEN_SPI)) begin
          if (!rdy_d) begin
            rx_out_d = rx_shift_q;
            rdy_d    = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          ferr_d = 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= WAIT_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and output flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_buf_q   <= '0;
      rx_out_q   <= '0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      rx_out_q   <= rx_out_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign miso      = (state_q == SHIFT) ? tx_shift_q[LEN_SPI-1] : 1'b0;
  assign rx_output = rx_out_q;
  assign rdy_spi   = rdy_q;
  assign spi_busy  = busy_q;
  assign overrun   = ovr_q;
  assign frame_err = ferr_q;

endmodule
